// File: rtl/spi_send_con_if.sv
// Bundle for the pixel-link transmitter: upstream word handshake plus the chip-side quad-line link.
// The slave modport is the transmitter's view; the master modport is the producer/receiver view.
interface spi_send_con_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  final_pixel_in;
    logic                  data_ready_out;
    logic [LINES-1:0]      chip_data_out;
    logic                  chip_clk_out;
    logic                  chip_sel_out;
    logic                  chip_final_out;
    logic                  busy_out;

    modport slave (
        input  data_in,
        input  data_valid_in,
        input  final_pixel_in,
        output data_ready_out,
        output chip_data_out,
        output chip_clk_out,
        output chip_sel_out,
        output chip_final_out,
        output busy_out
    );

    modport master (
        output data_in,
        output data_valid_in,
        output final_pixel_in,
        input  data_ready_out,
        input  chip_data_out,
        input  chip_clk_out,
        input  chip_sel_out,
        input  chip_final_out,
        input  busy_out
    );
endinterface

// File: rtl/spi_send_con.sv
// Quad-line pixel-link transmitter: serialises words MSB-beat-first, LINES bits per DCLK period,
// with a one-word holding register so back-to-back words stream inside a single CS frame.
//
// state | meaning
// IDLE  | CS high, waiting out the minimum CS-high dwell, then waiting for a held word
// SETUP | CS low, DCLK low for HALF cycles before the first beat
// SHIFT | one beat per CLK_DIV cycles, DCLK high in the second half of each beat
// HOLD  | CS low, DCLK low, data held for HALF cycles after the stream runs dry
module spi_send_con #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    spi_send_con_if.slave sif
);
    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int HALF  = CLK_DIV / 2;
    localparam int CW    = $clog2(CLK_DIV);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0] CNT_BEAT  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_RISE  = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         beat_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  word_final_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_final_q;
    logic                  hold_full_q;
    logic [LINES-1:0]      chip_data_q;
    logic                  chip_clk_q;
    logic                  chip_sel_q;
    logic                  chip_final_q;
    logic                  busy_q;

    logic accept;
    logic word_end;
    logic load_idle;
    logic load_chain;

    assign accept     = sif.data_valid_in && !hold_full_q;
    assign word_end   = (state_q == SHIFT) && (cnt_q == '0) && (beat_q == '0);
    assign load_idle  = (state_q == IDLE) && (cnt_q == '0) && hold_full_q;
    assign load_chain = word_end && hold_full_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            beat_q       <= '0;
            shift_q      <= '0;
            word_final_q <= 1'b0;
            hold_data_q  <= '0;
            hold_final_q <= 1'b0;
            hold_full_q  <= 1'b0;
            chip_data_q  <= '0;
            chip_clk_q   <= 1'b0;
            chip_sel_q   <= 1'b1;
            chip_final_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            if (accept) begin
                hold_data_q  <= sif.data_in;
                hold_final_q <= sif.final_pixel_in;
            end
            hold_full_q <= accept || (hold_full_q && !(load_idle || load_chain));

            case (state_q)
                IDLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (hold_full_q) begin
                        shift_q      <= hold_data_q;
                        word_final_q <= hold_final_q;
                        chip_sel_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        cnt_q        <= CNT_HALF;
                        state_q      <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        chip_data_q  <= shift_q[DATA_WIDTH-1 -: LINES];
                        shift_q      <= shift_q << LINES;
                        chip_final_q <= word_final_q;
                        beat_q       <= BEAT_LAST;
                        cnt_q        <= CNT_BEAT;
                        state_q      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q      <= cnt_q - CNT_ONE;
                        chip_clk_q <= (cnt_q <= CNT_RISE);
                    end else begin
                        chip_clk_q <= 1'b0;
                        cnt_q      <= CNT_BEAT;
                        if (beat_q != '0) begin
                            chip_data_q  <= shift_q[DATA_WIDTH-1 -: LINES];
                            shift_q      <= shift_q << LINES;
                            chip_final_q <= 1'b0;
                            beat_q       <= beat_q - BEAT_ONE;
                        end else if (hold_full_q) begin
                            // Chain the next word straight into beat 0 so DCLK stays continuous.
                            chip_data_q  <= hold_data_q[DATA_WIDTH-1 -: LINES];
                            shift_q      <= hold_data_q << LINES;
                            chip_final_q <= hold_final_q;
                            beat_q       <= BEAT_LAST;
                        end else begin
                            chip_final_q <= 1'b0;
                            cnt_q        <= CNT_HALF;
                            state_q      <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        // Reloading the counter enforces the CS-high dwell in IDLE.
                        chip_sel_q  <= 1'b1;
                        chip_data_q <= '0;
                        busy_q      <= 1'b0;
                        cnt_q       <= CNT_HALF;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sif.data_ready_out = !hold_full_q;
    assign sif.chip_data_out  = chip_data_q;
    assign sif.chip_clk_out   = chip_clk_q;
    assign sif.chip_sel_out   = chip_sel_q;
    assign sif.chip_final_out = chip_final_q;
    assign sif.busy_out       = busy_q;
endmodule
